des_key_sched: RTL

Parametrised DES key-schedule engine. It accepts a 64-bit origin key, optionally checks its odd parity, and iteratively generates all 16 round subkeys, one per cycle. The subkeys are stored in one of NUM_SLOTS key slots. Cipher datapaths read a subkey from the storage array by slot and round, with encrypt or decrypt ordering. The block sits between key ingest and the round pipeline, and replaces the separate key-check and per-round key-request pair.

---
 rtl/des_key_pkg.sv | 48 ++++
 rtl/des_key_pc2.sv | 15 +
 rtl/des_key_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/des_key_pkg.sv
// des_key_pkg: shared DES key-schedule types, permutation tables and helpers.
//   subkey_t      : 48-bit round subkey
//   PC1 / PC2     : permuted-choice tables, 1-based DES bit numbers
//   SHIFT         : per-round left-rotation amount of each 28-bit half
//   odd_parity_ok : 1 when every key byte has odd popcount
//   pc1_perm      : PC-1 of a 64-bit key (bit 63 = DES bit 1) -> {C, D}
//   rol28         : left rotation of a 28-bit half by one or two places
package des_key_pkg;

    localparam int NUM_ROUNDS = 16;

    typedef logic [47:0] subkey_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic odd_parity_ok(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^key[8*b +: 8]);
        return ok;
    endfunction

    // DES bit n (1-based, MSB first) lives at vector index 64-n.
    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] r;
        for (int j = 0; j < 56; j++) r[55-j] = key[64-PC1[j]];
        return r;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

endpackage

// File: rtl/des_key_pc2.sv
// des_key_pc2: PC-2 compression of the rotated C/D register pair.
//   cd     : {C, D}, 56 bits, cd[55] = C bit 1
//   subkey : 48-bit round subkey, subkey[47] = subkey bit 1
module des_key_pc2
    import des_key_pkg::*;
(
    input  logic [55:0] cd,
    output subkey_t     subkey
);

    for (genvar j = 0; j < 48; j++) begin : g_bit
        assign subkey[47-j] = cd[56-PC2[j]];
    end

endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES key schedule with NUM_SLOTS subkey slots.
//   Load side : key_in / key_slot_in / verify_in with key_in_valid/key_in_ready
//               handshake; key_done_out and key_err_out are one-cycle pulses;
//               slot_valid_out flags slots whose 16 subkeys are complete.
//   Read side : rd_valid_in / rd_slot_in / rd_round_in / rd_decrypt_in, answered
//               one cycle later on key_out / key_out_valid / key_miss_out.
module des_key_sched
    import des_key_pkg::*;
#(
    parameter int NUM_SLOTS    = 2,
    parameter int CHECK_PARITY = 1,
    parameter int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [63:0]          key_in,
    input  logic [SLOT_W-1:0]    key_slot_in,
    input  logic                 verify_in,
    input  logic                 key_in_valid,
    output logic                 key_in_ready,
    output logic                 key_done_out,
    output logic                 key_err_out,
    output logic [NUM_SLOTS-1:0] slot_valid_out,
    input  logic                 rd_valid_in,
    input  logic [SLOT_W-1:0]    rd_slot_in,
    input  logic [3:0]           rd_round_in,
    input  logic                 rd_decrypt_in,
    output logic [47:0]          key_out,
    output logic                 key_out_valid,
    output logic                 key_miss_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GEN  = 1'b1;

    // Slot indices are compared one bit wider so a non-power-of-two slot
    // count still rejects the unused codes.
    localparam logic [SLOT_W:0] SLOT_LIM = NUM_SLOTS[SLOT_W:0];

    logic [0:0]           state;
    logic [3:0]           cnt;
    logic [27:0]          c_q, d_q, c_rot, d_rot;
    logic [SLOT_W-1:0]    gen_slot;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [55:0]          pc1_key;
    logic                 accept, par_fail, shift2, gen_slot_ok, rd_slot_ok, rd_hit;
    logic [3:0]           rd_idx;
    subkey_t              gen_key;
    subkey_t              store [NUM_SLOTS][NUM_ROUNDS];

    assign key_in_ready   = (state == ST_IDLE);
    assign slot_valid_out = slot_valid;
    assign accept         = key_in_valid && key_in_ready;
    assign par_fail       = (CHECK_PARITY != 0) && verify_in && !odd_parity_ok(key_in);
    assign pc1_key        = pc1_perm(key_in);

    // The counter names the subkey being produced this cycle, so the
    // rotation for that round is applied combinationally ahead of PC-2.
    assign shift2 = (SHIFT[cnt] == 2);
    assign c_rot  = rol28(c_q, shift2);
    assign d_rot  = rol28(d_q, shift2);

    des_key_pc2 u_pc2 (
        .cd     ({c_rot, d_rot}),
        .subkey (gen_key)
    );

    assign gen_slot_ok = ({1'b0, gen_slot} < SLOT_LIM);
    assign rd_slot_ok  = ({1'b0, rd_slot_in} < SLOT_LIM);
    // 15 - r on a 4-bit index is a bitwise inversion.
    assign rd_idx      = rd_decrypt_in ? ~rd_round_in : rd_round_in;
    assign rd_hit      = rd_slot_ok && slot_valid[rd_slot_in];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            gen_slot     <= '0;
            slot_valid   <= '0;
            key_done_out <= 1'b0;
            key_err_out  <= 1'b0;
        end else begin
            key_done_out <= 1'b0;
            key_err_out  <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    if ({1'b0, key_slot_in} < SLOT_LIM) slot_valid[key_slot_in] <= 1'b0;
                    if (par_fail) begin
                        key_err_out <= 1'b1;
                    end else begin
                        c_q      <= pc1_key[55:28];
                        d_q      <= pc1_key[27:0];
                        cnt      <= '0;
                        gen_slot <= key_slot_in;
                        state    <= ST_GEN;
                    end
                end
            end else begin
                c_q <= c_rot;
                d_q <= d_rot;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state        <= ST_IDLE;
                    key_done_out <= 1'b1;
                    if (gen_slot_ok) slot_valid[gen_slot] <= 1'b1;
                end
            end
        end
    end

    // Subkey storage keeps its contents through reset; only the valid bits
    // say whether a slot may be read.
    always_ff @(posedge clk_in) begin
        if (state == ST_GEN && gen_slot_ok) store[gen_slot][cnt] <= gen_key;
    end

    // Reads see slot_valid as it was before the edge: a read racing the
    // done edge misses, a read racing a new load still gets the old data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            key_out       <= '0;
            key_out_valid <= 1'b0;
            key_miss_out  <= 1'b0;
        end else begin
            key_out_valid <= rd_valid_in;
            key_miss_out  <= rd_valid_in && !rd_hit;
            if (rd_valid_in) key_out <= rd_hit ? store[rd_slot_in][rd_idx] : '0;
        end
    end

endmodule
